// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory responder and its storage.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DEPTH_DEF   = 256;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port 32-bit RAM with write enable and registered read; contents never reset.
module mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Read-first port; the output register holds between accesses.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Request/response memory slave: accepts one request, waits LATENCY cycles,
// accesses the array for one cycle, then holds the response until taken.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic               r_rd_ok;

    logic               w_err;
    logic               w_ram_en;
    logic [31:0]        w_ram_rdata;

    assign w_err    = (r_addr[1:0] != 2'b00) || ((r_addr >> 2) >= 32'(DEPTH));
    assign w_ram_en = (r_state == ST_ACCESS) && !w_err;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (r_we),
        .i_addr  (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ok     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= CNT_W'(LATENCY);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= w_err;
                    r_rd_ok     <= !w_err && !r_we;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rd_ok     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read data comes straight from the RAM output register, which is frozen
    // while in RESP; writes and errors report zero.
    assign rsp_rdata = r_rd_ok ? w_ram_rdata : 32'h0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: instance a uses LATENCY=2, instance b uses LATENCY=0.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid_a = 1'b0, req_we_a = 1'b0, rsp_ready_a = 1'b0;
    logic [31:0] req_addr_a = '0, req_wdata_a = '0;
    logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
    logic [31:0] rsp_rdata_a;

    logic        req_valid_b = 1'b0, req_we_b = 1'b0, rsp_ready_b = 1'b1;
    logic [31:0] req_addr_b = '0, req_wdata_b = '0;
    logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
    logic [31:0] rsp_rdata_b;

    logic rdy_ctl_a = 1'b1;
    bit   stress_on = 1'b0;

    exp_t qa[$];
    exp_t qb[$];
    int   last_acc_a = 0, last_acc_b = 0, last_done_a = 0;

    mem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy(busy_a)
    );

    mem_responder #(.DEPTH(256), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response back-pressure for instance a: directed level or random in stress.
    always @(posedge clk) begin
        #2;
        rsp_ready_a = stress_on ? 1'($urandom_range(0, 1)) : rdy_ctl_a;
    end

    // Monitor a: pops on the first response cycle, then checks stability.
    bit          inr_a = 1'b0;
    logic [31:0] cur_rd_a;
    logic        cur_err_a;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            inr_a = 1'b0;
        end else if (rsp_valid_a) begin
            chk("a_busy_in_resp", 32'(busy_a), 32'd1);
            chk("a_req_ready_in_resp", 32'(req_ready_a), 32'd0);
            if (!inr_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_rdata", rsp_rdata_a, e.rdata);
                    chk("a_err", 32'(rsp_err_a), 32'(e.err));
                    chk("a_latency", 32'(cyc - e.acc), 32'd4);
                    $display("a: rsp rdata=%h err=%0d latency=%0d", rsp_rdata_a, rsp_err_a, cyc - e.acc);
                end
                inr_a     = 1'b1;
                cur_rd_a  = rsp_rdata_a;
                cur_err_a = rsp_err_a;
            end else begin
                chk("a_rdata_stable", rsp_rdata_a, cur_rd_a);
                chk("a_err_stable", 32'(rsp_err_a), 32'(cur_err_a));
            end
            if (rsp_ready_a) begin
                inr_a       = 1'b0;
                last_done_a = cyc + 1;
            end
        end
    end

    // Monitor b: ready is tied high, so each response is one cycle long.
    always @(negedge clk) begin
        exp_t e;
        if (rst && rsp_valid_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_rdata", rsp_rdata_b, e.rdata);
                chk("b_err", 32'(rsp_err_b), 32'(e.err));
                chk("b_latency", 32'(cyc - e.acc), 32'd2);
                chk("b_complete_cycles", 32'(cyc + 1 - e.acc), 32'd3);
                $display("b: rsp rdata=%h err=%0d latency=%0d", rsp_rdata_b, rsp_err_b, cyc - e.acc);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 one edge after the accept.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er,
                         input logic ee, input bit push);
        bit   done = 1'b0;
        exp_t e;
        if (d == 0) begin
            req_valid_a = 1'b1; req_we_a = we; req_addr_a = addr; req_wdata_a = wd;
        end else begin
            req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = wd;
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if ((d == 0 && req_ready_a) || (d == 1 && req_ready_b)) begin
                done    = 1'b1;
                e.rdata = er;
                e.err   = ee;
                e.acc   = cyc + 1;
                if (d == 0) last_acc_a = e.acc; else last_acc_b = e.acc;
                if (push) begin
                    if (d == 0) qa.push_back(e); else qb.push_back(e);
                end
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (d == 0) req_valid_a = 1'b0; else req_valid_b = 1'b0;
    endtask

    task automatic drain();
        bit idle = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clk);
            idle = (qa.size() == 0) && (qb.size() == 0) && !busy_a && !busy_b;
        end
        if (!idle) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mdl [256];

    task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        logic err;
        logic [31:0] er;
        err = (addr[1:0] != 2'b00) || (addr >= 32'h400);
        er  = (err || we) ? 32'h0 : mdl[addr[9:2]];
        if (!err && we) mdl[addr[9:2]] = wd;
        issue(0, we, addr, wd, er, err, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stress_addr [6];
        logic        b_ok;
        stress_addr = '{32'h0, 32'h10, 32'h40, 32'h3FC, 32'h2, 32'h800};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_rdata_a", rsp_rdata_a, 32'h0);
        chk("rst_err_a", 32'(rsp_err_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready_after_rst", 32'(req_ready_a), 32'd1);

        issue(0, 1'b1, 32'h10, 32'h11111111, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b1, 32'h00, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
        drain();

        // Reset in the middle of WAIT abandons the write.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        chk("a_in_wait_before_rst", 32'(busy_a), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_req_ready", 32'(req_ready_a), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b0, 1'b1);

        issue(0, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b1, 32'h400, 32'h55555555, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b0, 32'h00, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
        issue(0, 1'b1, 32'h3FC, 32'h12345678, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h3FC, 32'h0, 32'h12345678, 1'b0, 1'b1);
        drain();

        // Back-pressure with a second request held through the busy period.
        rdy_ctl_a = 1'b0;
        issue(0, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        fork
            begin
                b_ok = 1'b0;
                for (int k = 0; k < 50 && !b_ok; k++) begin
                    @(negedge clk);
                    b_ok = rsp_valid_a;
                end
                if (!b_ok) chk("bp_rsp_timeout", 32'd0, 32'd1);
                repeat (5) @(posedge clk);
                #1;
                rdy_ctl_a = 1'b1;
            end
            begin
                issue(0, 1'b0, 32'h3FC, 32'h0, 32'h12345678, 1'b0, 1'b1);
                chk("held_req_accept_cycle", 32'(last_acc_a), 32'(last_done_a + 1));
                $display("a: held request accepted at cycle %0d, previous done at %0d", last_acc_a, last_done_a);
            end
        join
        drain();

        // LATENCY=0 instance: writes then back-to-back reads of indices 0..3.
        for (int i = 0; i < 4; i++)
            issue(1, 1'b1, 32'(4 * i), 32'hB0000000 + 32'(i), 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            issue(1, 1'b0, 32'(4 * i), 32'h0, 32'hB0000000 + 32'(i), 1'b0, 1'b1);
        drain();

        // Random handshake stress on instance a, checked against a model.
        mdl[0]   = 32'h0BADF00D;
        mdl[4]   = 32'h11111111;
        mdl[16]  = 32'hCAFEF00D;
        mdl[255] = 32'h12345678;
        stress_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op(1'($urandom_range(0, 1)), stress_addr[$urandom_range(0, 5)], $urandom);
        end
        drain();
        stress_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 256, number of 32-bit words in the array, power of two.
- LATENCY, 2, wait cycles inserted before each access, range 0..15.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  processor request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  processor accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  the request was misaligned or out of range.
- busy  out  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, WAIT, ACCESS, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-005 On accept, the block SHALL capture req_we, req_addr and req_wdata, load the wait counter with LATENCY, and go to WAIT.
REQ-006 In WAIT:
- counter == 0: go to ACCESS.
- otherwise: decrement the counter.
REQ-007 ACCESS SHALL last exactly one cycle: perform the array read or write using the captured values, register the result, then go to RESP.
REQ-008 rsp_valid SHALL first be 1 exactly LATENCY+2 cycles after the accepting edge (LATENCY=0 gives 2 cycles).
REQ-009 In RESP:
- rsp_valid = 1, and rsp_rdata and rsp_err stay stable until rsp_ready = 1.
- rsp_ready = 1 at an edge: go to IDLE.
REQ-010 rsp_valid SHALL NOT depend combinationally on rsp_ready.
REQ-011 The block SHALL accept no new request before the previous response completes; a request held during a busy period SHALL be accepted on the first IDLE cycle.
REQ-012 Word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-013 Error conditions and handling:
- Error when req_addr[1:0] != 0, or when req_addr >> 2 >= DEPTH.
- On error: no array write, rsp_rdata = 0, rsp_err = 1.
REQ-014 A successful write SHALL return rsp_err = 0 and rsp_rdata = 0.
REQ-015 A successful read SHALL return the word most recently written to that index; a write followed by a read of the same index returns the new data.
REQ-016 busy SHALL equal (state != IDLE).
REQ-017 Handshake inputs SHALL be ignored outside their states: req_valid outside IDLE, rsp_ready outside RESP.

Reset
REQ-018 While rst = 0, asynchronously:
- state = IDLE, wait counter = 0.
- captured registers = 0.
- req_ready = 1 from the first cycle after rst deasserts.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction; a write not yet in ACCESS SHALL NOT modify the array.
REQ-020 Array contents SHALL NOT be reset.

Structure
REQ-021 A shared package mem_resp_pkg SHALL hold:
- the state enumeration.
- DEPTH and LATENCY defaults.
- the width of the wait counter (4 bits).
REQ-022 The storage SHALL be one sub-module, mem_array: a synchronous single-port 32-bit RAM with write enable and registered read, with no reset.

Verification
REQ-023 Reset behaviour: rst = 0 mid-WAIT of a write of 0xDEADBEEF to 0x10, then rst = 1, then read 0x10 -> rsp_valid = 0 during reset, and the read does not return 0xDEADBEEF.
REQ-024 Basic write/read, LATENCY=2: write 0xCAFEF00D to 0x40, then read 0x40 -> rsp_valid 4 cycles after each accept, rsp_rdata = 0xCAFEF00D, rsp_err = 0.
REQ-025 Error cases: read 0x41 -> rsp_err = 1, rdata = 0; write to 0x400 with DEPTH=256 -> rsp_err = 1 and array unchanged.
REQ-026 Back-pressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready = 0, and a pending req_valid is accepted only after the response completes.
REQ-027 LATENCY=0: back-to-back reads of index 0..3 with rsp_ready tied to 1 -> each response arrives 2 cycles after accept, and one transaction completes every 3 cycles.
REQ-028 Boundary: write, then read, the last word at 0x3FC -> correct data; a random handshake stress test checks every response against a scoreboard.
